fifo_ctrl_sync: RTL

FIFO_CTRL_SYNC -- requirements
Module: fifo_ctrl_sync

---
 rtl/fifo_ctrl_sync.sv | 102 ++++++++++
 1 files changed

// File: rtl/fifo_ctrl_sync.sv
// Synchronous FIFO controller: binary read/write pointers, occupancy and threshold
// flags, sticky overflow/underflow, and write strobe for an external FWFT memory.
module fifo_ctrl_sync #(
    parameter int unsigned addr_size          = 3,
    parameter int unsigned almost_full_level  = 6,
    parameter int unsigned almost_empty_level = 2
) (
    input  logic                 clock_i,
    input  logic                 reset_ni,
    input  logic                 clear_i,
    input  logic                 push_i,
    input  logic                 pop_i,
    output logic                 write_en_o,
    output logic                 write_full_o,
    output logic [addr_size-1:0] write_addr_o,
    output logic [addr_size-1:0] read_addr_o,
    output logic                 full_o,
    output logic                 empty_o,
    output logic                 almost_full_o,
    output logic                 almost_empty_o,
    output logic [addr_size:0]   level_o,
    output logic                 overflow_o,
    output logic                 underflow_o
);

    localparam logic [addr_size:0] af_level = (addr_size + 1)'(almost_full_level);
    localparam logic [addr_size:0] ae_level = (addr_size + 1)'(almost_empty_level);

    logic [addr_size:0] wr_ptr;
    logic [addr_size:0] rd_ptr;
    logic               running;
    logic               overflow_q;
    logic               underflow_q;
    logic               push_ok;
    logic               pop_ok;

    // Flags come from the registered pointers only; no request input feeds them.
    always_comb begin
        empty_o        = (wr_ptr == rd_ptr);
        full_o         = (wr_ptr[addr_size] != rd_ptr[addr_size]) &&
                         (wr_ptr[addr_size-1:0] == rd_ptr[addr_size-1:0]);
        level_o        = wr_ptr - rd_ptr;
        almost_full_o  = (level_o >= af_level);
        almost_empty_o = (level_o <= ae_level);
        write_full_o   = full_o;
        write_addr_o   = wr_ptr[addr_size-1:0];
        read_addr_o    = rd_ptr[addr_size-1:0];
        overflow_o     = overflow_q;
        underflow_o    = underflow_q;
    end

    // running is low while reset is held and until the first edge after release,
    // which keeps the write strobe quiet without using reset as a data signal.
    always_comb begin
        push_ok    = push_i && !full_o && !clear_i && running;
        pop_ok     = pop_i && !empty_o && !clear_i && running;
        write_en_o = push_ok;
    end

    always_ff @(posedge clock_i or negedge reset_ni) begin
        if (!reset_ni) begin
            running <= 1'b0;
        end else begin
            running <= 1'b1;
        end
    end

    always_ff @(posedge clock_i or negedge reset_ni) begin
        if (!reset_ni) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else if (clear_i) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push_ok) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop_ok) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
        end
    end

    always_ff @(posedge clock_i or negedge reset_ni) begin
        if (!reset_ni) begin
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else if (clear_i) begin
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            if (push_i && full_o) begin
                overflow_q <= 1'b1;
            end
            if (pop_i && empty_o) begin
                underflow_q <= 1'b1;
            end
        end
    end

endmodule
